fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, ROM word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first word address fetched after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits issuing new fetches.
REQ-006 SHALL have port redirect_valid  input  1  pipeline flush plus new PC request.
REQ-007 SHALL have port redirect_pc  input  ADDR_W  redirect target word address.
REQ-008 SHALL have port rom_addr  output  ADDR_W  address to ROM with 1-cycle registered read.
REQ-009 SHALL have port rom_rd  input  32  ROM data, valid the cycle after the address.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_instr output 32, out_pc output ADDR_W: consumer valid/ready stream.

Function
REQ-011 SHALL use FSM states IDLE (no issue) and RUN (issuing); IDLE->RUN when enable=1; RUN->IDLE when enable=0; in-flight data still delivered in IDLE.
REQ-012 SHALL issue a fetch in a cycle when state/enable permit and (buffered entries + in-flight) < 2; issue drives rom_addr=fetch_pc, then fetch_pc increments modulo 2^ADDR_W (wrap to 0 with no error).
REQ-013 SHALL hold a 2-entry FIFO of {instr, pc}; responses enter it the cycle rom_rd is valid.
REQ-014 SHALL bypass: if FIFO empty, the response is presented on out_valid/out_instr/out_pc in the same cycle rom_rd is valid (fetch-to-out latency 1 cycle).
REQ-015 SHALL sustain 1 instruction per cycle with out_ready held 1 and enable held 1.
REQ-016 SHALL hold out_instr/out_pc stable while out_valid=1 and out_ready=0; transfer only when both are 1.
REQ-017 SHALL on redirect_valid: drop FIFO contents, squash the in-flight response, force out_valid=0 that cycle, drive rom_addr=redirect_pc and issue it that cycle (if enable=1), fetch_pc=redirect_pc+1 next.
REQ-018 SHALL make redirect priority over same-cycle transfer; a handshake coinciding with redirect is not a transfer.
REQ-019 SHALL drive rom_addr=fetch_pc when not issuing (harmless read, response discarded).

Reset
REQ-020 SHALL on rst: state=IDLE, fetch_pc=RESET_PC, FIFO empty, in-flight cleared, out_valid=0, out_instr=0, out_pc=0.
REQ-021 SHALL discard any response for a fetch issued before a mid-operation reset.

Configuration
REQ-022 SHALL with FETCH_SEQUENCER_PERF_EN defined add output stall_cnt (16 bits): counts cycles with out_valid=1 and out_ready=0, saturates at 0xFFFF, reset to 0.
REQ-023 SHALL without FETCH_SEQUENCER_PERF_EN have no stall_cnt port and no counter logic; other behaviour identical.

Structure
REQ-024 SHALL place the FSM state enum and the FIFO depth constant (2) in package fetch_sequencer_pkg.
REQ-025 SHALL implement the 2-entry buffer as sub-module fetch_skid_fifo; FSM, PC and in-flight tracking stay in fetch_sequencer.

Verification (ROM word i = 0xA000_0000+i, ADDR_W=6)
REQ-026 SHALL test: reset release, enable=1, out_ready=1 -> out_valid first in cycle 2 after enable, out_pc 0,1,2... one per cycle, out_instr 0xA000_0000,...
REQ-027 SHALL test: out_ready=0 for 5 cycles mid-stream at pc 4 -> out_pc/out_instr held at 4/0xA000_0004, no more than 2 fetches outstanding, resume with 5 without loss or duplicate.
REQ-028 SHALL test: redirect_valid with redirect_pc=40 while FIFO holds 2 entries -> out_valid=0 that cycle, next outputs pc 40,41 with 0xA000_0028, 0xA000_0029.
REQ-029 SHALL test: run through pc 63 -> next out_pc 0, out_instr 0xA000_0000.
REQ-030 SHALL test: rst asserted with fetch in flight -> outputs zero immediately, first delivery after reset has out_pc=RESET_PC.
REQ-031 SHALL test (PERF_EN): hold out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=10.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared types and constants for the instruction fetch sequencer:
//   - fetch_state_t : issue-control FSM states (IDLE, RUN)
//   - FIFO_DEPTH    : depth of the response skid buffer
//   - CNT_W         : width of occupancy counters (holds 0..FIFO_DEPTH+1)
//   - PTR_W         : skid buffer pointer width
//   - sat_inc16     : saturating 16-bit increment used by the stall counter
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;
  localparam int PTR_W      = 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry buffer holding fetched {instr, pc} pairs that the consumer has not
// yet accepted. Flush empties it in one cycle (used on redirect).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : discard all entries (takes priority over push/pop)
//   push, push_data   : write one entry
//   pop               : remove the head entry
//   head_data         : current head entry (meaningful when !empty)
//   empty, count      : occupancy status
// Push is ignored when full (unless popping in the same cycle) and pop is
// ignored when empty, so a misbehaving caller cannot corrupt the pointers.
// -----------------------------------------------------------------------------
module fetch_skid_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_W = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              pop_ok_s;
  logic              push_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    push_ok_s = push && (!full_s || pop_ok_s);
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Issues sequential word fetches to a ROM with a 1-cycle registered read and
// streams {instr, pc} to a valid/ready consumer. At most two fetches are
// outstanding (buffered + in flight), which is enough for one instruction per
// cycle with no backpressure and never overflows the 2-entry skid buffer.
// A response is bypassed straight to the outputs when the buffer is empty.
// Optional feature macro: FETCH_SEQUENCER_PERF_EN adds a 16-bit saturating
// stall_cnt output (cycles with out_valid=1 and out_ready=0).
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   enable                       : permits new fetches (IDLE/RUN control)
//   redirect_valid, redirect_pc  : flush and restart fetching at redirect_pc
//   rom_addr, rom_rd             : ROM address out, ROM data back next cycle
//   out_valid, out_ready         : consumer handshake
//   out_instr, out_pc            : delivered instruction and its word address
//   stall_cnt                    : (FETCH_SEQUENCER_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int ENTRY_W = 32 + ADDR_W;

  fetch_state_t      state_r;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;

  logic              issue_ok_s;
  logic              issue_s;
  logic [CNT_W-1:0]  occupancy_s;
  logic              resp_valid_s;
  logic              fire_s;
  logic              push_s;
  logic              pop_s;

  logic [ENTRY_W-1:0] head_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;

  // Next state, issue decision, output steering and buffer control.
  always_comb begin
    state_nxt    = state_r;
    fetch_pc_nxt = fetch_pc_r;
    rom_addr     = fetch_pc_r;
    out_valid    = 1'b0;
    out_instr    = 32'd0;
    out_pc       = {ADDR_W{1'b0}};

    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A redirect empties the pipeline, so it may issue regardless of occupancy.
    occupancy_s = fifo_count_s + {{(CNT_W-1){1'b0}}, inflight_r};
    issue_ok_s  = (state_r == RUN) && enable;
    issue_s     = issue_ok_s && (redirect_valid || (occupancy_s < CNT_W'(FIFO_DEPTH)));

    if (redirect_valid) begin
      rom_addr = redirect_pc;
      if (issue_s) begin
        fetch_pc_nxt = redirect_pc + 1'b1;
      end else begin
        fetch_pc_nxt = redirect_pc;
      end
    end else if (issue_s) begin
      fetch_pc_nxt = fetch_pc_r + 1'b1;
    end else begin
      fetch_pc_nxt = fetch_pc_r;
    end

    // Buffered entries are older than the in-flight response, so they go first.
    if (redirect_valid) begin
      out_valid = 1'b0;
    end else if (!fifo_empty_s) begin
      out_valid = 1'b1;
      out_instr = head_s[ENTRY_W-1:ADDR_W];
      out_pc    = head_s[ADDR_W-1:0];
    end else if (inflight_r) begin
      out_valid = 1'b1;
      out_instr = rom_rd;
      out_pc    = inflight_pc_r;
    end else begin
      out_valid = 1'b0;
    end

    resp_valid_s = inflight_r && !redirect_valid;
    fire_s       = out_valid && out_ready;
    // A bypassed response that is accepted immediately never enters the buffer.
    push_s       = resp_valid_s && !(fifo_empty_s && out_ready);
    pop_s        = fire_s && !fifo_empty_s;
  end

  // FSM state, fetch PC and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      fetch_pc_r    <= ADDR_W'(RESET_PC);
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r       <= state_nxt;
      fetch_pc_r    <= fetch_pc_nxt;
      inflight_r    <= issue_s;
      inflight_pc_r <= rom_addr;
    end
  end

  fetch_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data ({rom_rd, inflight_pc_r}),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where valid data waits on the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_r <= sat_inc16(stall_cnt_r);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
